// File: rtl/tc_io_pkg.sv
// Shared types and constants for the TinyComp I/O ports.
package tc_io_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned WORD_W         = 32;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } rx_state_e;

endpackage

// File: rtl/tc_serial_in_port_if.sv
// Core-facing signals of the serial input port: serial line, pop/clear requests, word and status.
interface tc_serial_in_port_if;
  import tc_io_pkg::*;

  logic              RxD;
  logic              InStrobe;
  logic              ErrClear;
  logic [WORD_W-1:0] InData;
  logic              InRdy;
  logic              OverrunErr;
  logic              FrameErr;

  modport master (
    output RxD, InStrobe, ErrClear,
    input  InData, InRdy, OverrunErr, FrameErr
  );

  modport slave (
    input  RxD, InStrobe, ErrClear,
    output InData, InRdy, OverrunErr, FrameErr
  );

endinterface

// File: rtl/tc_sync_fifo.sv
// Single-clock FIFO; pointers carry one extra wrap bit to tell full from empty.
module tc_sync_fifo #(
  parameter int unsigned Width    = 32,
  parameter int unsigned AddrBits = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int unsigned     Depth  = 1 << AddrBits;
  localparam logic [AddrBits:0] PtrOne = 1;

  logic [Width-1:0]  mem [Depth];
  logic [AddrBits:0] wptr_q, rptr_q;
  logic              do_push, do_pop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AddrBits] != rptr_q[AddrBits]) &&
                 (wptr_q[AddrBits-1:0] == rptr_q[AddrBits-1:0]);

  // A pop frees the slot the same cycle, so push-while-full succeeds only alongside a pop.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign head = mem[rptr_q[AddrBits-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr_q[AddrBits-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrOne;
      if (do_pop)  rptr_q <= rptr_q + PtrOne;
    end
  end

endmodule

// File: rtl/tc_serial_in_port.sv
// 8N1 serial receiver packing four bytes little-endian into 32-bit words, buffered for the core.
module tc_serial_in_port
  import tc_io_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 434,
  parameter int unsigned FIFO_AW    = 3
) (
  input logic                Ph0,
  input logic                ResetN,
  tc_serial_in_port_if.slave bus
);

  localparam int unsigned CntW      = $clog2(BIT_CYCLES);
  localparam int unsigned ByteCntW  = $clog2(BYTES_PER_WORD);
  localparam logic [CntW-1:0] HalfLoad = CntW'(BIT_CYCLES / 2 - 1);
  localparam logic [CntW-1:0] FullLoad = CntW'(BIT_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne   = 1;
  localparam logic [ByteCntW-1:0] LastByte = ByteCntW'(BYTES_PER_WORD - 1);
  localparam logic [ByteCntW-1:0] ByteOne  = 1;

  // Reset asserts immediately but releases synchronously to Ph0.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge Ph0 or negedge ResetN) begin
    if (!ResetN) rst_sync_q <= 2'b00;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  logic [1:0] sync_q;
  logic       rx_prev_q;
  logic       rx_s;
  logic       fall;

  always_ff @(posedge Ph0 or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], bus.RxD};
      rx_prev_q <= sync_q[1];
    end
  end
  assign rx_s = sync_q[1];
  assign fall = rx_prev_q & ~rx_s;

  rx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            byte_valid;
  logic            frame_set;

  always_ff @(posedge Ph0 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    byte_valid = 1'b0;
    frame_set  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fall) begin
          state_d = StStart;
          cnt_d   = HalfLoad;
        end
      end
      StStart: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntOne;
        end else if (rx_s) begin
          state_d = StIdle;
        end else begin
          state_d   = StData;
          cnt_d     = FullLoad;
          bit_idx_d = '0;
        end
      end
      StData: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntOne;
        end else begin
          shreg_d   = {rx_s, shreg_q[7:1]};
          cnt_d     = FullLoad;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntOne;
        end else begin
          byte_valid = rx_s;
          frame_set  = ~rx_s;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Packer: word_q is complete the cycle push_q is high, well before the next byte can land.
  logic [ByteCntW-1:0] byte_cnt_q;
  logic [WORD_W-1:0]   word_q;
  logic                push_q;

  always_ff @(posedge Ph0 or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q <= '0;
      word_q     <= '0;
      push_q     <= 1'b0;
    end else begin
      push_q <= byte_valid && (byte_cnt_q == LastByte);
      if (byte_valid) begin
        word_q[{byte_cnt_q, 3'b000} +: 8] <= shreg_q;
        byte_cnt_q                       <= byte_cnt_q + ByteOne;
      end
    end
  end

  logic [WORD_W-1:0] head;
  logic              empty, full;
  logic              pop;

  assign pop = bus.InStrobe & ~empty;

  tc_sync_fifo #(
    .Width    (WORD_W),
    .AddrBits (FIFO_AW)
  ) u_fifo (
    .clk   (Ph0),
    .rst_n (rst_n),
    .push  (push_q),
    .pop   (pop),
    .wdata (word_q),
    .head  (head),
    .empty (empty),
    .full  (full)
  );

  logic overrun_set;
  logic overrun_q, frame_q;

  assign overrun_set = push_q & full & ~pop;

  // A new error event beats a simultaneous clear.
  always_ff @(posedge Ph0 or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      overrun_q <= overrun_set | (overrun_q & ~bus.ErrClear);
      frame_q   <= frame_set | (frame_q & ~bus.ErrClear);
    end
  end

  assign bus.InRdy      = ~empty;
  assign bus.InData     = empty ? '0 : head;
  assign bus.OverrunErr = overrun_q;
  assign bus.FrameErr   = frame_q;

endmodule

// File: tb/tb_tc_serial_in_port.sv
// Randomized bench for tc_serial_in_port against a byte/word queue model of the port.
module tb_tc_serial_in_port;
  import tc_io_pkg::*;

  localparam int unsigned BitCycles = 16;
  localparam int unsigned FifoAw    = 2;
  localparam int unsigned Depth     = 4;
  // Edges from start-bit drive to the push cycle: sync (2) + half bit + 8 bits + stop sample.
  localparam int unsigned PushEdge  = 155;

  logic Ph0    = 1'b0;
  logic ResetN = 1'b1;

  tc_serial_in_port_if bus ();

  tc_serial_in_port #(
    .BIT_CYCLES (BitCycles),
    .FIFO_AW    (FifoAw)
  ) dut (
    .Ph0    (Ph0),
    .ResetN (ResetN),
    .bus    (bus)
  );

  always #5 Ph0 = ~Ph0;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mq[$];
  logic [7:0]  pb[$];
  logic        m_ovr = 1'b0;
  logic        m_frm = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Ph0);
    #1;
  endtask

  task automatic model_byte(input logic [7:0] b);
    pb.push_back(b);
    if (pb.size() == BYTES_PER_WORD) begin
      if (mq.size() < Depth) mq.push_back({pb[3], pb[2], pb[1], pb[0]});
      else                   m_ovr = 1'b1;
      pb.delete();
    end
  endtask

  task automatic check_state(input string tag);
    check_val({tag, ".rdy"}, {31'b0, bus.InRdy}, {31'b0, mq.size() > 0});
    check_val({tag, ".data"}, bus.InData, (mq.size() > 0) ? mq[0] : 32'h0);
    check_val({tag, ".ovr"}, {31'b0, bus.OverrunErr}, {31'b0, m_ovr});
    check_val({tag, ".frm"}, {31'b0, bus.FrameErr}, {31'b0, m_frm});
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    bus.RxD = 1'b0;
    repeat (BitCycles) tick();
    for (int i = 0; i < 8; i++) begin
      bus.RxD = b[i];
      repeat (BitCycles) tick();
    end
    bus.RxD = stop_bit;
    repeat (BitCycles) tick();
    bus.RxD = 1'b1;
    repeat (2) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b1);
    model_byte(b);
  endtask

  task automatic send_random_bytes(input int n);
    for (int i = 0; i < n; i++) send_byte(8'($urandom_range(0, 255)));
  endtask

  task automatic pop_word(input string tag);
    check_state({tag, ".pre"});
    bus.InStrobe = 1'b1;
    tick();
    bus.InStrobe = 1'b0;
    if (mq.size() > 0) void'(mq.pop_front());
    check_state({tag, ".post"});
  endtask

  task automatic err_clear();
    bus.ErrClear = 1'b1;
    tick();
    bus.ErrClear = 1'b0;
    m_ovr = 1'b0;
    m_frm = 1'b0;
  endtask

  task automatic reset_dut(input string tag);
    ResetN = 1'b0;
    #1;
    check_val({tag, ".rdy"}, {31'b0, bus.InRdy}, 32'h0);
    check_val({tag, ".data"}, bus.InData, 32'h0);
    check_val({tag, ".ovr"}, {31'b0, bus.OverrunErr}, 32'h0);
    check_val({tag, ".frm"}, {31'b0, bus.FrameErr}, 32'h0);
    mq.delete();
    pb.delete();
    m_ovr = 1'b0;
    m_frm = 1'b0;
    bus.RxD = 1'b1;
    repeat (3) tick();
    ResetN = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    logic [7:0] b;
    bus.RxD      = 1'b1;
    bus.InStrobe = 1'b0;
    bus.ErrClear = 1'b0;
    #2;
    reset_dut("reset");
    check_state("idle");

    // 1: single word with exact push-to-InRdy latency
    send_byte(8'h78);
    send_byte(8'h56);
    send_byte(8'h34);
    fork
      send_frame(8'h12, 1'b1);
      begin
        repeat (PushEdge) tick();
        check_val("t1.rdy_push_cycle", {31'b0, bus.InRdy}, 32'h0);
        tick();
        check_val("t1.rdy_after_push", {31'b0, bus.InRdy}, 32'h1);
        check_val("t1.data_after_push", bus.InData, 32'h12345678);
      end
    join
    model_byte(8'h12);
    check_state("t1");
    pop_word("t1.pop");

    // 2: five words with no pops; fifth is dropped
    send_random_bytes(20);
    check_state("t2.full");
    for (int i = 0; i < Depth; i++) pop_word("t2.drain");
    pop_word("t2.empty_strobe");
    err_clear();
    check_state("t2.clr");

    // 3: bad stop bit between bytes 1 and 2 is skipped
    send_random_bytes(2);
    b = 8'($urandom_range(0, 255));
    send_frame(b, 1'b0);
    m_frm = 1'b1;
    check_state("t3.frame");
    send_random_bytes(2);
    check_state("t3.word");
    pop_word("t3.pop");
    err_clear();
    check_state("t3.clr");

    // 4: short low glitch assembles nothing
    bus.RxD = 1'b0;
    repeat (4) tick();
    bus.RxD = 1'b1;
    repeat (3 * BitCycles) tick();
    check_state("t4.glitch");
    send_random_bytes(4);
    check_state("t4.word");
    pop_word("t4.pop");

    // 5: push coincides with pop while full
    send_random_bytes(16 + 3);
    check_state("t5.full");
    b = 8'($urandom_range(0, 255));
    fork
      send_frame(b, 1'b1);
      begin
        repeat (PushEdge) tick();
        bus.InStrobe = 1'b1;
        tick();
        bus.InStrobe = 1'b0;
      end
    join
    void'(mq.pop_front());
    model_byte(b);
    check_state("t5.pushpop");
    for (int i = 0; i < Depth; i++) pop_word("t5.drain");

    // 6: reset mid-DATA with two bytes packed
    send_random_bytes(2);
    bus.RxD = 1'b0;
    repeat (BitCycles + 2 * BitCycles + 3) tick();
    reset_dut("t6.reset");
    check_state("t6.after");
    send_random_bytes(4);
    check_state("t6.word");
    pop_word("t6.pop");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tc_serial_in_port.md
Name: tc_serial_in_port

Overview:
- Input-side peripheral feeding the TinyComp input instruction (op 5) and the InRdy skip test.
- Receives 8N1 asynchronous serial bytes on RxD and packs four bytes into a 32-bit word, little-endian.
- Buffers completed words in a small FIFO, presents the head word on InData with InRdy, and pops on InStrobe.
- Sits directly upstream of the core: its InData/InRdy drive the core inputs, and the core's InStrobe drives its pop.

Parameters:
- BIT_CYCLES, 434, Ph0 cycles per serial bit (115200 baud at 50 MHz). Must be >= 4.
- FIFO_AW, 3, log2 of FIFO depth in words (default 8 words).

Ports:
- Ph0  in  1  system clock; the same Ph0 that clocks the core PC.
- ResetN  in  1  asynchronous, active-low reset.
- RxD  in  1  serial line, idle high, asynchronous to Ph0.
- InStrobe  in  1  core is executing an Input instruction; pop request.
- ErrClear  in  1  clears the sticky error flags.
- InData  out  32  head-of-FIFO word; 0 when the FIFO is empty.
- InRdy  out  1  FIFO is non-empty.
- OverrunErr  out  1  sticky: a completed word was dropped because the FIFO was full.
- FrameErr  out  1  sticky: a stop bit was sampled low.

Behaviour:
- Reset (async assert, sync deassert inside Ph0 domain):
  - FSM returns to IDLE; FIFO, byte count and error flags are cleared.
  - Synchronizer flops reset to 1.
  - InRdy=0, InData=0, OverrunErr=0, FrameErr=0.
  - A frame in progress is abandoned. Partial words are discarded.
- RxD passes through a 2-flop synchronizer. Edge detection uses the synchronized value and its previous value.
- RX FSM states: IDLE, START, DATA, STOP.
- IDLE: on a synchronized falling edge, go to START and load the bit counter with BIT_CYCLES/2-1.
- START: decrement the counter. At 0, sample the line:
  - 1 means a glitch; return to IDLE.
  - 0 means a valid start; load BIT_CYCLES-1, clear the bit index, go to DATA.
- DATA: at counter 0, shift the sample in LSB-first and reload the counter. After the 8th bit, go to STOP.
- STOP: at counter 0, sample the line:
  - 1: the byte is valid and goes to the packer.
  - 0: set FrameErr, discard the byte, leave the packer untouched.
  - In both cases return to IDLE. A line held low produces no new falling edge, so no new frame starts until the line returns high.
- Packer:
  - Byte k (k=0..3) lands in word bits [8k+7:8k].
  - The 2-bit byte count wraps 3->0.
  - On the 4th byte, a push is issued in the same cycle.
- FIFO:
  - Depth 2^FIFO_AW.
  - Pointers are FIFO_AW+1 bits for full/empty detection.
  - A push happens on the cycle after the stop-bit sample of the 4th byte. InRdy rises one cycle after the push.
  - Pop = InStrobe & InRdy.
  - InStrobe while empty does nothing, and InData reads 0.
  - InStrobe is high once per instruction cycle, so each Ph0 cycle it is high pops exactly one word.
  - InData is a combinational read of the head entry, gated to 0 when empty.
- Boundary cases:
  - Push while full with no pop: the word is dropped and OverrunErr is set. FIFO contents are unchanged.
  - Push and pop together while full: both succeed and the FIFO stays full.
  - Push and pop together while empty: the push succeeds, nothing pops, and InRdy rises next cycle.
- Error flags:
  - Sticky until ErrClear.
  - If ErrClear and a new error event occur in the same cycle, the set wins.
- RX continues regardless of FIFO state. There is no flow control on RxD.

Decomposition:
- Shared package tc_io_pkg:
  - RX state enum (IDLE/START/DATA/STOP).
  - BYTES_PER_WORD=4.
  - Word width 32.
- Sub-module tc_sync_fifo:
  - Parameterized by width and address bits.
  - Interface: push/pop/data-in/head/empty/full.
  - Reusable later for an output-side port.

Test Plan (BIT_CYCLES=16, FIFO_AW=2):
1. Send bytes 0x78,0x56,0x34,0x12 -> InRdy=1 one cycle after the push, InData=0x12345678. Pulse InStrobe for one cycle -> InRdy=0, InData=0.
2. Send a 16-byte stream (4 words) then a 5th word with no pops -> four words read back in order via InStrobe. OverrunErr=1, 5th word absent. ErrClear -> OverrunErr=0.
3. Send a frame with a low stop bit between bytes 1 and 2 -> FrameErr=1. The byte is skipped; the next valid byte becomes byte 2 of the word.
4. RxD low pulse of 4 cycles (< BIT_CYCLES/2) -> FSM returns to IDLE, no byte is assembled, no flags are set.
5. FIFO full, 4th-byte push coincides with InStrobe -> old head popped, new word appended, FIFO still full, OverrunErr stays 0.
6. Assert ResetN low mid-DATA with 2 bytes packed -> outputs 0 immediately. After release, a fresh 4-byte word assembles correctly from byte 0.
